// File: rtl/axi4s_sync_fifo.sv
// Single-clock AXI4-Stream FIFO: a DEPTH-1 entry RAM feeding a first-word fall-through output register.
// Define AXI4S_FIFO_PACKET_MODE_EN for store-and-forward operation; cut-through otherwise.
module axi4s_sync_fifo #(
  parameter  int TDATA_WIDTH = 8,
  parameter  int TUSER_WIDTH = 1,
  parameter  int TDEST_WIDTH = 1,
  parameter  int TID_WIDTH   = 1,
  parameter  int DEPTH       = 16,
  localparam int TKEEP_WIDTH = TDATA_WIDTH / 8,
  localparam int CW          = $clog2(DEPTH + 1)
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic [TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic [TKEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic [TKEEP_WIDTH-1:0] s_axis_tstrb,
  input  logic [TUSER_WIDTH-1:0] s_axis_tuser,
  input  logic [TDEST_WIDTH-1:0] s_axis_tdest,
  input  logic [TID_WIDTH-1:0]   s_axis_tid,
  input  logic                   s_axis_tlast,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic [TDATA_WIDTH-1:0] m_axis_tdata,
  output logic [TKEEP_WIDTH-1:0] m_axis_tkeep,
  output logic [TKEEP_WIDTH-1:0] m_axis_tstrb,
  output logic [TUSER_WIDTH-1:0] m_axis_tuser,
  output logic [TDEST_WIDTH-1:0] m_axis_tdest,
  output logic [TID_WIDTH-1:0]   m_axis_tid,
  output logic                   m_axis_tlast,
  output logic [CW-1:0]          fill_count,
  output logic                   full,
  output logic                   empty
);

  localparam int RAM_DEPTH = DEPTH - 1;
  localparam int PW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam int EW = TDATA_WIDTH + 2 * TKEEP_WIDTH + TUSER_WIDTH + TDEST_WIDTH + TID_WIDTH + 1;
  localparam logic [PW-1:0] PTR_LAST = PW'(RAM_DEPTH - 1);
  localparam logic [CW-1:0] FILL_MAX = CW'(DEPTH);

  logic [EW-1:0] mem_q [RAM_DEPTH];
  logic [EW-1:0] out_q, out_d;
  logic          out_full_q, out_full_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] ram_count_q, ram_count_d;
  logic [CW-1:0] fill_count_q, fill_count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          ready_q, ready_d;
  logic [EW-1:0] s_beat;
  logic          wr_en, rd_en, out_load, ram_pop, ram_push, m_valid;

  assign s_beat = {s_axis_tdata, s_axis_tkeep, s_axis_tstrb, s_axis_tuser,
                   s_axis_tdest, s_axis_tid, s_axis_tlast};
  assign {m_axis_tdata, m_axis_tkeep, m_axis_tstrb, m_axis_tuser,
          m_axis_tdest, m_axis_tid, m_axis_tlast} = out_q;

  assign s_axis_tready = ready_q && !areset;
  assign m_axis_tvalid = m_valid;
  assign fill_count    = fill_count_q;
  assign full          = full_q;
  assign empty         = empty_q;

  assign wr_en    = s_axis_tvalid && s_axis_tready;
  assign rd_en    = m_valid && m_axis_tready;
  assign out_load = !out_full_q || rd_en;
  assign ram_pop  = out_load && (ram_count_q != '0);
  // A write bypasses the RAM only when the output register is free and nothing older is queued.
  assign ram_push = wr_en && !(out_load && (ram_count_q == '0));

`ifdef AXI4S_FIFO_PACKET_MODE_EN
  logic [CW-1:0] pkt_count_q, pkt_count_d;

  always_comb begin
    pkt_count_d = pkt_count_q + CW'(wr_en && s_axis_tlast) - CW'(rd_en && m_axis_tlast);
  end

  always_ff @(posedge aclk) begin
    if (areset) pkt_count_q <= '0;
    else        pkt_count_q <= pkt_count_d;
  end

  // Releasing beats while full lets an oversize packet drain instead of deadlocking.
  assign m_valid = out_full_q && ((pkt_count_q != '0) || full_q);
`else
  assign m_valid = out_full_q;
`endif

  always_comb begin
    out_d      = out_q;
    out_full_d = out_full_q;
    if (ram_pop) begin
      out_d      = mem_q[rd_ptr_q];
      out_full_d = 1'b1;
    end else if (out_load) begin
      if (wr_en) begin
        out_d      = s_beat;
        out_full_d = 1'b1;
      end else begin
        out_full_d = 1'b0;
      end
    end

    wr_ptr_d = wr_ptr_q;
    if (ram_push) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1);
    rd_ptr_d = rd_ptr_q;
    if (ram_pop) rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PW'(1);

    ram_count_d  = ram_count_q + CW'(ram_push) - CW'(ram_pop);
    fill_count_d = fill_count_q + CW'(wr_en) - CW'(rd_en);
    full_d       = (fill_count_d == FILL_MAX);
    empty_d      = (fill_count_d == '0);
    ready_d      = !full_d;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      out_q        <= '0;
      out_full_q   <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      ram_count_q  <= '0;
      fill_count_q <= '0;
      full_q       <= 1'b0;
      empty_q      <= 1'b1;
      ready_q      <= 1'b0;
    end else begin
      out_q        <= out_d;
      out_full_q   <= out_full_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      ram_count_q  <= ram_count_d;
      fill_count_q <= fill_count_d;
      full_q       <= full_d;
      empty_q      <= empty_d;
      ready_q      <= ready_d;
    end
  end

  // Storage array is deliberately left out of reset.
  always_ff @(posedge aclk) begin
    if (ram_push) mem_q[wr_ptr_q] <= s_beat;
  end

endmodule

// File: tb/tb_axi4s_sync_fifo.sv
// Self-checking bench for axi4s_sync_fifo: directed vector table, corner sequences and random traffic
// compared against a queue-based model; follows AXI4S_FIFO_PACKET_MODE_EN when defined.
module tb_axi4s_sync_fifo;

  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [7:0] data;
    logic       keep;
    logic       strb;
    logic       user;
    logic       dest;
    logic       id;
    logic       last;
  } beat_t;

  typedef struct {
    bit         s_valid;
    logic [7:0] s_data;
    bit         s_last;
    bit         m_ready;
    bit         e_valid;
    logic [7:0] e_data;
    bit         e_last;
    int         e_fill;
  } vec_t;

  logic          aclk = 1'b0;
  logic          areset;
  logic          s_axis_tvalid, s_axis_tready;
  logic [7:0]    s_axis_tdata;
  logic [0:0]    s_axis_tkeep, s_axis_tstrb, s_axis_tuser, s_axis_tdest, s_axis_tid;
  logic          s_axis_tlast;
  logic          m_axis_tvalid, m_axis_tready;
  logic [7:0]    m_axis_tdata;
  logic [0:0]    m_axis_tkeep, m_axis_tstrb, m_axis_tuser, m_axis_tdest, m_axis_tid;
  logic          m_axis_tlast;
  logic [CW-1:0] fill_count;
  logic          full, empty;

  int    total = 0;
  int    bad   = 0;
  beat_t model_q[$];
  bit    rst_done = 1'b0;
  beat_t drv_beat;
  int    n_wr = 0;
  int    n_rd = 0;
  bit    last_wr = 1'b0;
  vec_t  vecs[8];
  int    nvec;

  always #5 aclk = ~aclk;

  axi4s_sync_fifo #(
    .TDATA_WIDTH(8), .TUSER_WIDTH(1), .TDEST_WIDTH(1), .TID_WIDTH(1), .DEPTH(DEPTH)
  ) dut (
    .aclk(aclk), .areset(areset),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tstrb(s_axis_tstrb),
    .s_axis_tuser(s_axis_tuser), .s_axis_tdest(s_axis_tdest), .s_axis_tid(s_axis_tid),
    .s_axis_tlast(s_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tstrb(m_axis_tstrb),
    .m_axis_tuser(m_axis_tuser), .m_axis_tdest(m_axis_tdest), .m_axis_tid(m_axis_tid),
    .m_axis_tlast(m_axis_tlast),
    .fill_count(fill_count), .full(full), .empty(empty)
  );

  // Master may present data when anything is stored (cut-through), or when a whole packet
  // is stored or the FIFO is full (store-and-forward).
  function automatic bit model_mvalid();
`ifdef AXI4S_FIFO_PACKET_MODE_EN
    int pkts = 0;
    foreach (model_q[i]) if (model_q[i].last) pkts++;
    return (pkts > 0) || (model_q.size() == DEPTH);
`else
    return model_q.size() > 0;
`endif
  endfunction

  function automatic bit model_ready();
    return rst_done && !areset && (model_q.size() < DEPTH);
  endfunction

  function automatic beat_t dut_beat();
    return beat_t'({m_axis_tdata, m_axis_tkeep, m_axis_tstrb, m_axis_tuser,
                    m_axis_tdest, m_axis_tid, m_axis_tlast});
  endfunction

  function automatic beat_t rand_beat(input bit last);
    beat_t b;
    b.data = 8'($urandom_range(0, 255));
    b.keep = 1'($urandom_range(0, 1));
    b.strb = 1'($urandom_range(0, 1));
    b.user = 1'($urandom_range(0, 1));
    b.dest = 1'($urandom_range(0, 1));
    b.id   = 1'($urandom_range(0, 1));
    b.last = last;
    return b;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input bit valid, input beat_t b, input bit rdy);
    drv_beat      = b;
    s_axis_tvalid = valid;
    {s_axis_tdata, s_axis_tkeep, s_axis_tstrb, s_axis_tuser,
     s_axis_tdest, s_axis_tid, s_axis_tlast} = b;
    m_axis_tready = rdy;
  endtask

  task automatic checkOutput();
    bit ev;
    ev = model_mvalid();
    chk("s_tready", 32'(s_axis_tready), 32'(model_ready()));
    chk("m_tvalid", 32'(m_axis_tvalid), 32'(ev));
    chk("fill_count", 32'(fill_count), 32'(model_q.size()));
    chk("full", 32'(full), 32'(model_q.size() == DEPTH));
    chk("empty", 32'(empty), 32'(model_q.size() == 0));
    if (ev) chk("m_payload", 32'(dut_beat()), 32'(model_q[0]));
  endtask

  // One clock edge: decide handshakes from pre-edge values, advance model, then compare.
  task automatic step();
    bit wr, rd;
    wr = s_axis_tvalid && model_ready();
    rd = model_mvalid() && m_axis_tready;
    @(posedge aclk);
    #1;
    last_wr = 1'b0;
    if (areset) begin
      model_q.delete();
      rst_done = 1'b0;
    end else begin
      if (rd) begin
        void'(model_q.pop_front());
        n_rd++;
      end
      if (wr) begin
        model_q.push_back(drv_beat);
        n_wr++;
        last_wr = 1'b1;
      end
      rst_done = 1'b1;
    end
    checkOutput();
  endtask

  task automatic doReset();
    areset = 1'b1;
    applyStimulus(1'b0, '0, 1'b0);
    step();
    step();
    chk("rst_tdata", 32'(m_axis_tdata), 32'd0);
    chk("rst_tlast", 32'(m_axis_tlast), 32'd0);
    chk("rst_tkeep", 32'(m_axis_tkeep), 32'd0);
    areset = 1'b0;
    #1;
    chk("rst_release_tready", 32'(s_axis_tready), 32'd0);
    step();
  endtask

  task automatic drain(input string name, input int limit);
    applyStimulus(1'b0, '0, 1'b1);
    for (int c = 0; c < limit && model_q.size() != 0; c++) step();
    chk(name, 32'(model_q.size()), 32'd0);
  endtask

  initial begin
    beat_t b;
    bit    pending;
    int    sent;

`ifdef AXI4S_FIFO_PACKET_MODE_EN
    vecs[0] = '{1'b1, 8'hA1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1};
    vecs[1] = '{1'b1, 8'hA2, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 2};
    vecs[2] = '{1'b1, 8'hA3, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 3};
    vecs[3] = '{1'b1, 8'hA4, 1'b1, 1'b1, 1'b1, 8'hA1, 1'b0, 4};
    vecs[4] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hA2, 1'b0, 3};
    vecs[5] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hA3, 1'b0, 2};
    vecs[6] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hA4, 1'b1, 1};
    vecs[7] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 0};
    nvec = 8;
`else
    vecs[0] = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 8'h11, 1'b0, 1};
    vecs[1] = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 8'h22, 1'b0, 1};
    vecs[2] = '{1'b1, 8'h33, 1'b1, 1'b1, 1'b1, 8'h33, 1'b1, 1};
    vecs[3] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 0};
    nvec = 4;
`endif

    areset = 1'b1;
    applyStimulus(1'b0, '0, 1'b0);
    $display("[TB] reset and directed vectors");
    doReset();
    for (int i = 0; i < nvec; i++) begin
      b      = '0;
      b.data = vecs[i].s_data;
      b.last = vecs[i].s_last;
      applyStimulus(vecs[i].s_valid, b, vecs[i].m_ready);
      step();
      chk($sformatf("vec%0d_tvalid", i), 32'(m_axis_tvalid), 32'(vecs[i].e_valid));
      chk($sformatf("vec%0d_fill", i), 32'(fill_count), 32'(vecs[i].e_fill));
      if (vecs[i].e_valid) begin
        chk($sformatf("vec%0d_tdata", i), 32'(m_axis_tdata), 32'(vecs[i].e_data));
        chk($sformatf("vec%0d_tlast", i), 32'(m_axis_tlast), 32'(vecs[i].e_last));
      end
    end

    $display("[TB] fill to full then drain");
    doReset();
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, rand_beat(i == DEPTH - 1), 1'b0);
      step();
    end
    applyStimulus(1'b1, rand_beat(1'b1), 1'b0);
    step();
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_count_max", 32'(fill_count), 32'(DEPTH));
    chk("fill_tready_low", 32'(s_axis_tready), 32'd0);
    n_rd = 0;
    applyStimulus(1'b0, '0, 1'b1);
    for (int i = 0; i < DEPTH; i++) step();
    chk("drain_no_bubble", 32'(n_rd), 32'(DEPTH));
    chk("drain_empty", 32'(empty), 32'd1);

    $display("[TB] full with both sides active");
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, rand_beat(1'b1), 1'b0);
      step();
    end
    n_rd = 0;
    n_wr = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, rand_beat(1'b1), 1'b1);
      step();
    end
    chk("thru_reads", 32'(n_rd), 32'd20);
    chk("thru_writes", 32'(n_wr), 32'd19);
    drain("thru_drain", 100);

    $display("[TB] oversize packet without tlast");
    doReset();
    n_wr = 0;
    n_rd = 0;
    pending = 1'b0;
    for (int c = 0; c < 300 && n_wr < 20; c++) begin
      if (!pending) b = rand_beat(1'b0);
      applyStimulus(1'b1, b, 1'b1);
      step();
      pending = !last_wr;
    end
    chk("escape_accepted", 32'(n_wr), 32'd20);
    chk("escape_reads_seen", 32'(n_rd > 0), 32'd1);
    sent = n_wr;
    b = rand_beat(1'b1);
    for (int c = 0; c < 100 && n_wr == sent; c++) begin
      applyStimulus(1'b1, b, 1'b1);
      step();
    end
    chk("escape_tail_accepted", 32'(n_wr), 32'(sent + 1));
    drain("escape_drain", 100);

    $display("[TB] random traffic");
    doReset();
    n_wr = 0;
    n_rd = 0;
    pending = 1'b0;
    for (int c = 0; c < 6000 && n_wr < 1000; c++) begin
      if (!pending) begin
        b = rand_beat((n_wr == 999) ? 1'b1 : 1'($urandom_range(0, 3) == 0));
        applyStimulus(1'($urandom_range(0, 1)), b, 1'($urandom_range(0, 1)));
      end else begin
        applyStimulus(1'b1, b, 1'($urandom_range(0, 1)));
      end
      step();
      pending = s_axis_tvalid && !last_wr;
    end
    chk("rand_accepted", 32'(n_wr), 32'd1000);
    drain("rand_drain", 200);
    chk("rand_count_match", 32'(n_rd), 32'(n_wr));

    $display("[TB] reset with seven beats stored");
    doReset();
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b1, rand_beat(1'b0), 1'b0);
      step();
    end
    chk("pre_rst_fill", 32'(fill_count), 32'd7);
    areset = 1'b1;
    applyStimulus(1'b0, '0, 1'b0);
    step();
    chk("rst7_tdata", 32'(m_axis_tdata), 32'd0);
    chk("rst7_tvalid", 32'(m_axis_tvalid), 32'd0);
    areset = 1'b0;
    #1;
    chk("rst7_release_tready", 32'(s_axis_tready), 32'd0);
    step();
    chk("rst7_tready_up", 32'(s_axis_tready), 32'd1);
    applyStimulus(1'b0, '0, 1'b1);
    for (int i = 0; i < 3; i++) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
